// File: rtl/controller_seqout.sv
// controller_seqout: sequential half of the 8-bit processor controller.
// Holds the state register and decodes state + ISR into datapath strobes.
//
// Optional feature macro: CTRL_PERF_COUNT_EN (performance counters).
//
// Parameters:
//   CNT_W        width of the performance counters
// Ports:
//   clock        system clock, all state updates on rising edge
//   reset        synchronous active-high reset
//   nextstate    next-state code from the combinational next-state block
//   ISR          instruction register: [7:6] op, [5:3] Rx, [2:0] Ry/imm
//   stall        hold state and suppress strobes this cycle
//   currstate    registered state, fed back to the next-state block
//   isr_load     load ISR from memory at PCR
//   pcr_inc      increment PCR
//   reg_write    write bus value into register reg_wsel
//   reg_wsel     register file write index
//   reg_rsel     register file read index
//   bus_sel      operand bus source (00 reg, 01 imm, 10 ALU)
//   alu_a_load   latch bus into ALU operand A
//   alu_b_load   latch bus into ALU operand B
//   alu_op       ALU function, 0 ADD / 1 XOR
//   instr_done   one-cycle pulse when an instruction retires
//   error        controller is in the ERROR state
//   instr_count  retired-instruction counter (0 when counters omitted)
//   cycle_count  non-stalled cycle counter (0 when counters omitted)

module controller_seqout #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       nextstate,
   input  logic [7:0]       ISR,
   input  logic             stall,
   output logic [3:0]       currstate,
   output logic             isr_load,
   output logic             pcr_inc,
   output logic             reg_write,
   output logic [2:0]       reg_wsel,
   output logic [2:0]       reg_rsel,
   output logic [1:0]       bus_sel,
   output logic             alu_a_load,
   output logic             alu_b_load,
   output logic             alu_op,
   output logic             instr_done,
   output logic             error,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'b0000,
      S_DECODE  = 4'b0001,
      S_AX1     = 4'b0010,
      S_AX2     = 4'b0011,
      S_AX3     = 4'b0100,
      S_EXEC_L  = 4'b0101,
      S_EXEC_M  = 4'b0110,
      S_INC     = 4'b0111,
      S_ERROR   = 4'b1111
   } state_e;

   localparam logic [1:0] BUS_REG = 2'b00;
   localparam logic [1:0] BUS_IMM = 2'b01;
   localparam logic [1:0] BUS_ALU = 2'b10;

   state_e state_q;
   state_e state_d;

   logic [2:0] rx;
   logic [2:0] ry;
   logic       strobe_en;
   logic       ns_valid;

   // The opcode is decoded by the external next-state block.
   logic unused_isr;
   assign unused_isr = ISR[7];

   assign rx        = ISR[5:3];
   assign ry        = ISR[2:0];
   assign strobe_en = ~stall & ~reset;
   assign currstate = state_q;

   // Codes 1000..1110 are not states; 1111 is ERROR itself.
   always_comb begin
      ns_valid = 1'b0;
      case (nextstate)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b0110, 4'b0111,
         4'b1111: ns_valid = 1'b1;
         default: ns_valid = 1'b0;
      endcase
   end

   // ERROR is sticky: only reset (in the register process) leaves it.
   always_comb begin
      state_d = state_q;
      if (state_q == S_ERROR) begin
         state_d = S_ERROR;
      end else if (stall) begin
         state_d = state_q;
      end else if (ns_valid) begin
         state_d = state_e'(nextstate);
      end else begin
         state_d = S_ERROR;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobe decode; a stalled state re-issues its strobes once stall drops.
   always_comb begin
      isr_load   = 1'b0;
      pcr_inc    = 1'b0;
      reg_write  = 1'b0;
      reg_wsel   = 3'd0;
      reg_rsel   = 3'd0;
      bus_sel    = BUS_REG;
      alu_a_load = 1'b0;
      alu_b_load = 1'b0;
      alu_op     = 1'b0;
      instr_done = 1'b0;
      if (strobe_en) begin
         case (state_q)
            S_FETCH: begin
               isr_load = 1'b1;
            end
            S_EXEC_M: begin
               reg_write = 1'b1;
               reg_wsel  = rx;
               reg_rsel  = ry;
               bus_sel   = BUS_REG;
            end
            S_EXEC_L: begin
               reg_write = 1'b1;
               reg_wsel  = rx;
               bus_sel   = BUS_IMM;
            end
            S_AX1: begin
               alu_a_load = 1'b1;
               reg_rsel   = rx;
               bus_sel    = BUS_REG;
            end
            S_AX2: begin
               alu_b_load = 1'b1;
               reg_rsel   = ry;
               bus_sel    = BUS_REG;
            end
            S_AX3: begin
               reg_write = 1'b1;
               reg_wsel  = rx;
               bus_sel   = BUS_ALU;
               alu_op    = ISR[6];
            end
            S_INC: begin
               pcr_inc    = 1'b1;
               instr_done = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Decoded from state alone so it stays visible while stalled.
   assign error = (state_q == S_ERROR);

`ifdef CTRL_PERF_COUNT_EN
   logic [CNT_W-1:0] instr_cnt_q;
   logic [CNT_W-1:0] instr_cnt_d;
   logic [CNT_W-1:0] cyc_cnt_q;
   logic [CNT_W-1:0] cyc_cnt_d;
   logic             cyc_en;

   assign cyc_en = ~reset & ~stall & ~error;

   // Plain binary add; wraps naturally at 2^CNT_W.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      cyc_cnt_d   = cyc_cnt_q;
      if (instr_done) begin
         instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (cyc_en) begin
         cyc_cnt_d = cyc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instr_cnt_q <= '0;
         cyc_cnt_q   <= '0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
      end
   end

   assign instr_count = instr_cnt_q;
   assign cycle_count = cyc_cnt_q;
`else
   assign instr_count = '0;
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_controller_seqout.sv
// tb_controller_seqout: self-checking bench for controller_seqout.
// Acts as the next-state block and checks against a phase-table model.

module tb_controller_seqout;

   localparam int CNT_W = 4;

   logic             clock;
   logic             reset;
   logic [3:0]       nextstate;
   logic [7:0]       ISR;
   logic             stall;
   logic [3:0]       currstate;
   logic             isr_load;
   logic             pcr_inc;
   logic             reg_write;
   logic [2:0]       reg_wsel;
   logic [2:0]       reg_rsel;
   logic [1:0]       bus_sel;
   logic             alu_a_load;
   logic             alu_b_load;
   logic             alu_op;
   logic             instr_done;
   logic             error;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] cycle_count;

   controller_seqout #(.CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .nextstate   (nextstate),
      .ISR         (ISR),
      .stall       (stall),
      .currstate   (currstate),
      .isr_load    (isr_load),
      .pcr_inc     (pcr_inc),
      .reg_write   (reg_write),
      .reg_wsel    (reg_wsel),
      .reg_rsel    (reg_rsel),
      .bus_sel     (bus_sel),
      .alu_a_load  (alu_a_load),
      .alu_b_load  (alu_b_load),
      .alu_op      (alu_op),
      .instr_done  (instr_done),
      .error       (error),
      .instr_count (instr_count),
      .cycle_count (cycle_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total;
   int bad;
   int m_instr;
   int m_cyc;
   int cyc_idx;
   int obs_rw;
   int done_at;

   logic       force_ns;
   logic [3:0] force_val;

   // External next-state block: instruction flow from the opcode.
   function automatic logic [3:0] ns_of(input logic [3:0] s,
                                        input logic [1:0] op);
      case (s)
         4'd0: return 4'd1;
         4'd1: return (op == 2'b00) ? 4'd6 :
                      (op == 2'b01) ? 4'd5 : 4'd2;
         4'd2: return 4'd3;
         4'd3: return 4'd4;
         4'd4: return 4'd7;
         4'd5: return 4'd7;
         4'd6: return 4'd7;
         default: return 4'd0;
      endcase
   endfunction

   always_comb begin
      nextstate = ns_of(currstate, ISR[7:6]);
      if (force_ns) nextstate = force_val;
   end

   function automatic logic [15:0] mk(
      input logic il, input logic pi, input logic rw,
      input logic [2:0] ws, input logic [2:0] rs,
      input logic [1:0] bs, input logic a, input logic b,
      input logic op, input logic dn, input logic er);
      return {il, pi, rw, ws, rs, bs, a, b, op, dn, er};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {isr_load, pcr_inc, reg_write, reg_wsel, reg_rsel,
              bus_sel, alu_a_load, alu_b_load, alu_op,
              instr_done, error};
   endfunction

   function automatic int n_phases(input logic [7:0] isr);
      return isr[7] ? 6 : 4;
   endfunction

   // Phase ph of an instruction -> state code it must show.
   function automatic logic [3:0] ph_state(input logic [7:0] isr,
                                           input int ph);
      if (ph == 0) return 4'd0;
      if (ph == 1) return 4'd1;
      if (ph == n_phases(isr) - 1) return 4'd7;
      if (!isr[7]) return isr[6] ? 4'd5 : 4'd6;
      if (ph == 2) return 4'd2;
      if (ph == 3) return 4'd3;
      return 4'd4;
   endfunction

   function automatic logic [15:0] ph_strobes(input logic [7:0] isr,
                                              input int ph);
      logic [2:0] rx;
      logic [2:0] ry;
      rx = isr[5:3];
      ry = isr[2:0];
      case (ph_state(isr, ph))
         4'd0: return mk(1,0,0,0,0,2'b00,0,0,0,0,0);
         4'd6: return mk(0,0,1,rx,ry,2'b00,0,0,0,0,0);
         4'd5: return mk(0,0,1,rx,0,2'b01,0,0,0,0,0);
         4'd2: return mk(0,0,0,0,rx,2'b00,1,0,0,0,0);
         4'd3: return mk(0,0,0,0,ry,2'b00,0,1,0,0,0);
         4'd4: return mk(0,0,1,rx,0,2'b10,0,0,isr[6],0,0);
         4'd7: return mk(0,1,0,0,0,2'b00,0,0,0,1,0);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt(input int m);
`ifdef CTRL_PERF_COUNT_EN
      return CNT_W'(m % (1 << CNT_W));
`else
      return '0 & CNT_W'(m);
`endif
   endfunction

   task automatic check_cnt(input string nm);
      total++;
      if (instr_count !== exp_cnt(m_instr)) begin
         bad++;
         $display("FAIL %s instr_count got %0d want %0d",
                  nm, instr_count, exp_cnt(m_instr));
      end
      total++;
      if (cycle_count !== exp_cnt(m_cyc)) begin
         bad++;
         $display("FAIL %s cycle_count got %0d want %0d",
                  nm, cycle_count, exp_cnt(m_cyc));
      end
   endtask

   // One clock of an instruction phase; entered at posedge+1.
   task automatic step(input logic [7:0] isr, input int ph,
                       input logic stl);
      logic [15:0] exp_sb;
      stall = stl;
      @(negedge clock);
      exp_sb = stl ? 16'h0000 : ph_strobes(isr, ph);
      total++;
      if (currstate !== ph_state(isr, ph)) begin
         bad++;
         $display("FAIL state isr=%b ph=%0d got %h want %h",
                  isr, ph, currstate, ph_state(isr, ph));
      end
      total++;
      if (obs_vec() !== exp_sb) begin
         bad++;
         $display("FAIL strobes isr=%b ph=%0d stall=%0b got %h want %h",
                  isr, ph, stl, obs_vec(), exp_sb);
      end
      check_cnt("step");
      cyc_idx++;
      if (reg_write === 1'b1) obs_rw++;
      if (instr_done === 1'b1) done_at = cyc_idx;
      @(posedge clock);
      #1;
      if (!stl) begin
         m_cyc++;
         if (ph == n_phases(isr) - 1) m_instr++;
      end
   endtask

   task automatic run_instr(input logic [7:0] isr, input int pct,
                            input int sph, input int sn);
      int n;
      ISR = isr;
      cyc_idx = 0;
      obs_rw = 0;
      done_at = 0;
      for (int ph = 0; ph < n_phases(isr); ph++) begin
         if (ph == sph) n = sn;
         else if ($urandom_range(99) < pct) n = $urandom_range(1, 2);
         else n = 0;
         for (int s = 0; s < n; s++) step(isr, ph, 1'b1);
         step(isr, ph, 1'b0);
      end
      stall = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      force_ns = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_instr = 0;
      m_cyc = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stall = 1'b1;
      ISR = 8'h00;
      force_ns = 1'b0;
      @(posedge clock);
      #1;
      @(negedge clock);
      m_instr = 0;
      m_cyc = 0;
      total++;
      if (currstate !== 4'd0) begin
         bad++;
         $display("FAIL reset_state got %h want 0", currstate);
      end
      total++;
      if (obs_vec() !== 16'h0000) begin
         bad++;
         $display("FAIL reset_strobes got %h want 0000", obs_vec());
      end
      check_cnt("reset");
      @(posedge clock);
      #1;
      reset = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_move();
      run_instr(8'b00_011_010, 0, -1, 0);
      total++;
      if (done_at !== 4) begin
         bad++;
         $display("FAIL move_len done at %0d want 4", done_at);
      end
   endtask

   task automatic test_xor();
      run_instr(8'b11_001_101, 0, -1, 0);
      total++;
      if (done_at !== 6) begin
         bad++;
         $display("FAIL xor_len done at %0d want 6", done_at);
      end
   endtask

   task automatic test_load_stall();
      run_instr(8'b01_100_111, 0, 2, 3);
      total++;
      if (done_at !== 7) begin
         bad++;
         $display("FAIL load_stall_len done at %0d want 7", done_at);
      end
      total++;
      if (obs_rw !== 1) begin
         bad++;
         $display("FAIL load_stall_writes got %0d want 1", obs_rw);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_instr(8'($urandom), 30, -1, 0);
      end
   endtask

   task automatic test_error();
      do_reset();
      ISR = 8'($urandom);
      force_ns = 1'b1;
      force_val = 4'b1010;
      step(ISR, 0, 1'b0);
      force_val = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         stall = 1'($urandom_range(1));
         @(negedge clock);
         total++;
         if (currstate !== 4'hF) begin
            bad++;
            $display("FAIL err_state i=%0d got %h want f", i, currstate);
         end
         total++;
         if (obs_vec() !== mk(0,0,0,0,0,2'b00,0,0,0,0,1)) begin
            bad++;
            $display("FAIL err_strobes i=%0d got %h want 0001",
                     i, obs_vec());
         end
         check_cnt("err");
         @(posedge clock);
         #1;
      end
      force_ns = 1'b0;
      stall = 1'b0;
      do_reset();
      step(ISR, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [7:0] isr;
      isr = 8'b10_010_110;
      do_reset();
      ISR = isr;
      step(isr, 0, 1'b0);
      step(isr, 1, 1'b0);
      step(isr, 2, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (currstate !== 4'd3 || obs_vec() !== 16'h0000) begin
         bad++;
         $display("FAIL rst_mid_ax2 got st=%h sb=%h want 3/0000",
                  currstate, obs_vec());
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_instr = 0;
      m_cyc = 0;
      step(isr, 0, 1'b0);
      step(isr, 1, 1'b0);
      reset = 1'b1;
      stall = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      stall = 1'b0;
      m_instr = 0;
      m_cyc = 0;
      step(isr, 0, 1'b0);
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         run_instr({2'b00, 6'($urandom)}, 0, -1, 0);
      end
      @(negedge clock);
      total++;
`ifdef CTRL_PERF_COUNT_EN
      if (instr_count !== 4'd1 || cycle_count !== 4'd4) begin
         bad++;
         $display("FAIL wrap got i=%0d c=%0d want 1/4",
                  instr_count, cycle_count);
      end
`else
      if (instr_count !== 4'd0 || cycle_count !== 4'd0) begin
         bad++;
         $display("FAIL wrap got i=%0d c=%0d want 0/0",
                  instr_count, cycle_count);
      end
`endif
      @(posedge clock);
      #1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      m_instr = 0;
      m_cyc = 0;
      cyc_idx = 0;
      obs_rw = 0;
      done_at = 0;
      force_ns = 1'b0;
      force_val = 4'd0;
      reset = 1'b1;
      stall = 1'b0;
      ISR = 8'h00;
      test_reset();
      test_move();
      test_xor();
      test_load_stall();
      test_random();
      test_error();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
